// File: rtl/gpr_pkg.sv
// Register-file geometry shared by general_purpose_registers and its write-back arbiter.
package gpr_pkg;

    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 32;
    localparam int TW        = $clog2(NUM_REGS);

    typedef logic [TW-1:0]        gpr_idx_t;
    typedef logic [REG_WIDTH-1:0] gpr_dat_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin scan: grants up to NUM_WR_PRTS requesters with distinct
// targets and compacts the grants onto output ports in scan order.
module wb_rr_picker
    import gpr_pkg::*;
#(
    parameter int NUM_REQ     = 6,
    parameter int NUM_WR_PRTS = 4,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              hold,
    input  logic [IW-1:0]                     rr_ptr,
    input  logic [NUM_REQ-1:0]                req_vld,
    input  gpr_idx_t [NUM_REQ-1:0]            req_trgt,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_WR_PRTS-1:0]            port_vld,
    output logic [NUM_WR_PRTS-1:0][IW-1:0]    port_sel,
    output logic [IW-1:0]                     last_idx
);

    gpr_idx_t [NUM_WR_PRTS-1:0] port_trgt;
    logic [IW-1:0]              idx;
    logic                       conflict;
    int                         n_gnt;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        gnt       = '0;
        port_vld  = '0;
        port_sel  = '0;
        port_trgt = '0;
        last_idx  = rr_ptr;
        idx       = '0;
        conflict  = 1'b0;
        n_gnt     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx      = wrap_add(rr_ptr, i);
            conflict = 1'b0;
            // port_vld doubles as "already granted this cycle" for the conflict check
            for (int k = 0; k < NUM_WR_PRTS; k++) begin
                if (port_vld[k] && port_trgt[k] == req_trgt[idx]) conflict = 1'b1;
            end
            if (!hold && req_vld[idx] && n_gnt < NUM_WR_PRTS && !conflict) begin
                gnt[idx] = 1'b1;
                for (int k = 0; k < NUM_WR_PRTS; k++) begin
                    if (k == n_gnt) begin
                        port_vld[k]  = 1'b1;
                        port_sel[k]  = idx;
                        port_trgt[k] = req_trgt[idx];
                    end
                end
                last_idx = idx;
                n_gnt    = n_gnt + 1;
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter: round-robin grants from NUM_REQ units onto NUM_WR_PRTS
// registered register-file write ports, plus a busy map of the output stage.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ     = 6,
    parameter int NUM_WR_PRTS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   hold,
    input  logic [NUM_REQ-1:0]                     req_vld,
    input  gpr_idx_t [NUM_REQ-1:0]                 req_trgt,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]      req_dat,
    output logic [NUM_REQ-1:0]                     req_rdy,
    output logic [NUM_WR_PRTS-1:0]                 we,
    output gpr_idx_t [NUM_WR_PRTS-1:0]             wr_trgt,
    output logic [NUM_WR_PRTS-1:0][REG_WIDTH-1:0]  wr_dat,
    output logic [NUM_REGS-1:0]                    wb_busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]                   rr_ptr;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_WR_PRTS-1:0]          port_vld;
    logic [NUM_WR_PRTS-1:0][IW-1:0]  port_sel;
    logic [IW-1:0]                   last_idx;

    wb_rr_picker #(
        .NUM_REQ     (NUM_REQ),
        .NUM_WR_PRTS (NUM_WR_PRTS)
    ) u_picker (
        .hold     (hold),
        .rr_ptr   (rr_ptr),
        .req_vld  (req_vld),
        .req_trgt (req_trgt),
        .gnt      (gnt),
        .port_vld (port_vld),
        .port_sel (port_sel),
        .last_idx (last_idx)
    );

    // Grants are masked during reset so no requester believes it was accepted
    assign req_rdy = gnt & {NUM_REQ{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            we      <= '0;
            wr_trgt <= '0;
            wr_dat  <= '0;
        end else begin
            we <= port_vld;
            if (|gnt) begin
                rr_ptr <= (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
            end
            for (int k = 0; k < NUM_WR_PRTS; k++) begin
                if (port_vld[k]) begin
                    wr_trgt[k] <= req_trgt[port_sel[k]];
                    wr_dat[k]  <= req_dat[port_sel[k]];
                end
            end
        end
    end

    always_comb begin
        wb_busy = '0;
        for (int k = 0; k < NUM_WR_PRTS; k++) begin
            if (we[k]) wb_busy[wr_trgt[k]] = 1'b1;
        end
    end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter for `general_purpose_registers`. It collects result writes from NUM_REQ execution units, each using a valid/ready handshake, and grants at most NUM_WR_PRTS of them per cycle using round-robin priority. No two grants in the same cycle may target the same register. Granted writes are registered and driven onto the register file's `we`/`wr_trgt`/`wr_dat` ports one cycle later.

## Interface
- REG_WIDTH, 32, data width of one register.
- NUM_REGS, 32, register count; target index width TW = $clog2(NUM_REGS).
- NUM_REQ, 6, number of requesting units.
- NUM_WR_PRTS, 4, register-file write ports; must be ≤ NUM_REQ.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- hold  in  1  freeze; while high there are no grants and write enables are deasserted.
- req_vld  in  [NUM_REQ]  per-requester write request.
- req_trgt  in  [NUM_REQ][TW]  target register.
- req_dat  in  [NUM_REQ][REG_WIDTH]  write data.
- req_rdy  out  [NUM_REQ]  grant; combinational this cycle.
- we  out  [NUM_WR_PRTS]  write enable to the register file; registered.
- wr_trgt  out  [NUM_WR_PRTS][TW]  target to the register file; registered.
- wr_dat  out  [NUM_WR_PRTS][REG_WIDTH]  data to the register file; registered.
- wb_busy  out  [NUM_REGS]  one-hot-per-register map of writes currently on the output stage.

## Operation
- A transfer completes when req_vld[i] and req_rdy[i] are both high at the rising edge.
- While req_vld is high and not yet granted, the requester holds req_trgt and req_dat stable.
- req_vld may drop without a grant; the request is then withdrawn and nothing is written.
- Selection, purely combinational from rr_ptr, req_vld, req_trgt and hold:
  - Scan i = rr_ptr, rr_ptr+1, … mod NUM_REQ, once around.
  - Grant requester i if req_vld[i] is high, fewer than NUM_WR_PRTS grants have been made so far, and req_trgt[i] differs from every target already granted this cycle.
  - A requester skipped for a target conflict is not granted; later requesters in the scan may still be granted.
- Port mapping: the k-th grant in scan order drives output port k. Ports with no grant have we[k]=0; their wr_trgt and wr_dat hold their previous values.
- rr_ptr update: if any grant was made, rr_ptr ← (index of the last granted requester + 1) mod NUM_REQ; otherwise it is unchanged. This bounds the wait of any held request to NUM_REQ cycles, even under continuous conflicts.
- hold=1: req_rdy=0, next-cycle we=0, rr_ptr unchanged.
- wb_busy[r] = OR over k of (we[k] && wr_trgt[k]==r), decoded from the output registers.
- Reset, asynchronous and immediate while rst=0:
  - we=0, wr_trgt=0, wr_dat=0, rr_ptr=0, wb_busy=0.
  - req_rdy is forced to 0 while rst is low.
  - A write on the output stage when reset asserts is dropped.

## Timing
- Grant in cycle N: the write appears on we/wr_trgt/wr_dat during cycle N+1. The register updates at the end of N+1 and is readable from N+2.
- Throughput: up to NUM_WR_PRTS writes per cycle, sustained with no bubbles.
- The output registers load every cycle; we is 0 in any cycle that follows a cycle with no grants.
- The combinational path from req_vld/req_trgt to req_rdy must meet single-cycle timing. Requesters must not feed req_rdy back into req_vld combinationally.
- First possible grant is the first rising edge after rst deasserts.

## Structure
- Shared package `gpr_pkg`: REG_WIDTH, NUM_REGS, derived TW, and typedef `gpr_idx_t` (logic [TW-1:0]). The same package is imported by `general_purpose_registers`.
- One combinational sub-module, `wb_rr_picker`, holds the rotate-scan, conflict check and grant-to-port compaction. It outputs the grant vector, the port-select indices and the last-granted index.
- The top level holds rr_ptr, the output registers and the wb_busy decode.

## Test plan
- Reset mid-write: assert rst low while we=4'b0011 → all outputs 0 immediately, no register-file write. After release, req_vld[2] with target 7 → req_rdy[2]=1 on the first edge; next cycle we[0]=1, wr_trgt[0]=7.
- Saturation: all 6 requesters valid with distinct targets 1–6, rr_ptr=0 → grants to requesters 0–3 on ports 0–3, rr_ptr becomes 4. Next cycle requesters 4 and 5 are granted (ports 0–1), then 0 and 1; rr_ptr wraps correctly.
- Target conflict: requesters 0 and 1 both target register 5, rr_ptr=0 → only requester 0 is granted and requester 2 (target 9) is still granted. Next cycle requester 1 is granted; wr_trgt never has duplicates with we high.
- Fairness under persistent conflict: all 6 requesters target register 3 and stay valid → exactly one grant per cycle, in order 0,1,2,3,4,5; each is granted within 6 cycles.
- hold: hold=1 for 3 cycles with 4 valid requests → req_rdy=0 and we=0 throughout, rr_ptr unchanged. The first cycle after hold drops grants the same 4 requesters.
- Latency and busy map: requester 1 writes 0xDEADBEEF to register 12 in cycle N → we[0]=1, wr_dat[0]=0xDEADBEEF and wb_busy[12]=1 in N+1. A register-file read of register 12 returns 0xDEADBEEF in N+2.
